// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        MD_DONE = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_perf_counters.sv
// Free-running stall and flush event counters for performance debug.
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Both counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            stall_count <= stall_count + CNT_W'(stall_inc);
            flush_count <= flush_count + CNT_W'(flush_inc);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush control for the 5-stage pipeline: load-use, ID-resolved
// branches/jumps and multi-cycle mul/div occupancy of EX.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IDEX_MemRead,
    input  logic [REG_IDX_W-1:0] IDEX_Rt,
    input  logic [REG_IDX_W-1:0] IFID_Rs,
    input  logic [REG_IDX_W-1:0] IFID_Rt,
    input  logic                 IFID_UsesRt,
    input  logic                 BranchTaken,
    input  logic                 Jump,
    input  logic                 MDStart,
    output logic                 PCStall,
    output logic                 IFIDStall,
    output logic                 IFIDFlush,
    output logic                 IDEXStall,
    output logic                 IDEXFlush,
    output logic                 EXMEMFlush,
    output logic                 MDBusy,
    output logic [CNT_W-1:0]     StallCount,
    output logic [CNT_W-1:0]     FlushCount
);

    localparam int MD_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_CYCLES - 2);

    hz_state_e       state, state_nxt;
    logic [MD_W-1:0] md_rem, md_rem_nxt;
    logic            load_use;
    logic            md_stall;

    always_comb begin
        PCStall    = 1'b0;
        IFIDStall  = 1'b0;
        IFIDFlush  = 1'b0;
        IDEXStall  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        MDBusy     = 1'b0;
        state_nxt  = state;
        md_rem_nxt = md_rem;

        load_use = IDEX_MemRead && (IDEX_Rt != REG_ZERO) &&
                   ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
        // MDStart in MD_DONE belongs to the finishing op, so it cannot restart a stall.
        md_stall = (state == MD_WAIT) || ((state == RUN) && MDStart);

        if (!rst) begin
            if (md_stall) begin
                PCStall    = 1'b1;
                IFIDStall  = 1'b1;
                IDEXStall  = 1'b1;
                EXMEMFlush = 1'b1;
                MDBusy     = 1'b1;
            end else if (load_use) begin
                PCStall   = 1'b1;
                IFIDStall = 1'b1;
                IDEXFlush = 1'b1;
            end else if (BranchTaken || Jump) begin
                IFIDFlush = 1'b1;
            end
        end

        case (state)
            RUN: begin
                if (MDStart) begin
                    md_rem_nxt = MD_LOAD;
                    state_nxt  = (MD_LOAD != '0) ? MD_WAIT : MD_DONE;
                end
            end
            MD_WAIT: begin
                md_rem_nxt = md_rem - MD_W'(1);
                if (md_rem == MD_W'(1)) state_nxt = MD_DONE;
            end
            MD_DONE:  state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            md_rem <= '0;
        end else begin
            state  <= state_nxt;
            md_rem <= md_rem_nxt;
        end
    end

    hazard_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk        (clk),
        .rst        (rst),
        .stall_inc  (PCStall),
        .flush_inc  (IFIDFlush),
        .stall_count(StallCount),
        .flush_count(FlushCount)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (MD_CYCLES 4 and 2) on shared inputs.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       IDEX_MemRead;
    logic [4:0] IDEX_Rt, IFID_Rs, IFID_Rt;
    logic       IFID_UsesRt, BranchTaken, Jump, MDStart;

    logic        pcs4, ifs4, iff4, ids4, idf4, exf4, mdb4;
    logic        pcs2, ifs2, iff2, ids2, idf2, exf2, mdb2;
    logic [31:0] sc4, fc4, sc2, fc2;
    logic [6:0]  o4, o2;

    int checks = 0;
    int errors = 0;

    // Model state: position of the current mul/div within its EX occupancy (0 = none).
    int          md_pos[2];
    int          mdc[2] = '{4, 2};
    logic [31:0] m_stall[2], m_flush[2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_CYCLES(4), .CNT_W(32)) dut4 (
        .clk(clk), .rst(rst), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .BranchTaken(BranchTaken), .Jump(Jump), .MDStart(MDStart),
        .PCStall(pcs4), .IFIDStall(ifs4), .IFIDFlush(iff4), .IDEXStall(ids4),
        .IDEXFlush(idf4), .EXMEMFlush(exf4), .MDBusy(mdb4),
        .StallCount(sc4), .FlushCount(fc4));

    pipe_hazard_ctrl #(.MD_CYCLES(2), .CNT_W(32)) dut2 (
        .clk(clk), .rst(rst), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .BranchTaken(BranchTaken), .Jump(Jump), .MDStart(MDStart),
        .PCStall(pcs2), .IFIDStall(ifs2), .IFIDFlush(iff2), .IDEXStall(ids2),
        .IDEXFlush(idf2), .EXMEMFlush(exf2), .MDBusy(mdb2),
        .StallCount(sc2), .FlushCount(fc2));

    // {PCStall, IFIDStall, IFIDFlush, IDEXStall, IDEXFlush, EXMEMFlush, MDBusy}
    assign o4 = {pcs4, ifs4, iff4, ids4, idf4, exf4, mdb4};
    assign o2 = {pcs2, ifs2, iff2, ids2, idf2, exf2, mdb2};

    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_MD   = 7'b1101011;
    localparam logic [6:0] O_LU   = 7'b1100100;
    localparam logic [6:0] O_BR   = 7'b0010000;

    typedef struct {
        logic       mr;
        logic [4:0] ex_rt, rs, rt;
        logic       uses, br, j;
        logic [6:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic apply(input logic r, input logic mr, input logic [4:0] ex_rt,
                         input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic br, input logic j, input logic md);
        rst = r; IDEX_MemRead = mr; IDEX_Rt = ex_rt; IFID_Rs = rs; IFID_Rt = rt;
        IFID_UsesRt = uses; BranchTaken = br; Jump = j; MDStart = md;
        #2;
    endtask

    function automatic int cur_pos(input int d);
        if (md_pos[d] != 0) return md_pos[d] + 1;
        return MDStart ? 1 : 0;
    endfunction

    function automatic logic [6:0] model_out(input int d);
        int  pos;
        logic lu;
        pos = cur_pos(d);
        lu  = IDEX_MemRead && IDEX_Rt != 0 &&
              (IDEX_Rt == IFID_Rs || (IFID_UsesRt && IDEX_Rt == IFID_Rt));
        if (rst) return O_NONE;
        if (pos != 0 && pos < mdc[d]) return O_MD;
        if (lu) return O_LU;
        if (BranchTaken || Jump) return O_BR;
        return O_NONE;
    endfunction

    // Compare outputs with the model, take the clock edge, then compare counters.
    task automatic advance();
        logic [6:0] e[2];
        int         p[2];
        for (int d = 0; d < 2; d++) begin
            e[d] = model_out(d);
            p[d] = cur_pos(d);
        end
        check("model_out_md4", {25'd0, o4}, {25'd0, e[0]});
        check("model_out_md2", {25'd0, o2}, {25'd0, e[1]});
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                md_pos[d] = 0; m_stall[d] = '0; m_flush[d] = '0;
            end else begin
                md_pos[d]  = (p[d] == 0 || p[d] == mdc[d]) ? 0 : p[d];
                m_stall[d] = m_stall[d] + 32'(e[d][6]);
                m_flush[d] = m_flush[d] + 32'(e[d][4]);
            end
        end
        #1;
        check("stall_cnt_md4", sc4, m_stall[0]);
        check("flush_cnt_md4", fc4, m_flush[0]);
        check("stall_cnt_md2", sc2, m_stall[1]);
        check("flush_cnt_md2", fc2, m_flush[1]);
    endtask

    task automatic do_reset();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        advance();
    endtask

    vec_t vecs[9];
    logic [6:0] busy4[4];
    logic [6:0] busy2[4];

    initial begin
        md_pos  = '{0, 0};
        m_stall = '{32'd0, 32'd0};
        m_flush = '{32'd0, 32'd0};

        vecs[0] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[1] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, O_NONE};
        vecs[2] = '{1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[3] = '{1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, O_LU};
        vecs[4] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, O_BR};
        vecs[5] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, O_LU};
        vecs[6] = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, O_BR};
        vecs[7] = '{1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, O_NONE};
        vecs[8] = '{1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b0, 1'b1, O_LU};

        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        do_reset();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_out_md4", {25'd0, o4}, 32'd0);
        check("reset_out_md2", {25'd0, o2}, 32'd0);
        check("reset_stallcnt", sc4, 32'd0);
        check("reset_flushcnt", fc4, 32'd0);
        advance();

        // Single-cycle hazard table from an idle pipeline.
        for (int i = 0; i < 9; i++) begin
            apply(0, vecs[i].mr, vecs[i].ex_rt, vecs[i].rs, vecs[i].rt, vecs[i].uses,
                  vecs[i].br, vecs[i].j, 0);
            check($sformatf("vec%0d_md4", i), {25'd0, o4}, {25'd0, vecs[i].exp});
            check($sformatf("vec%0d_md2", i), {25'd0, o2}, {25'd0, vecs[i].exp});
            advance();
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        advance();

        // Mul/div held four cycles.
        busy4 = '{O_MD, O_MD, O_MD, O_NONE};
        busy2 = '{O_MD, O_NONE, O_MD, O_NONE};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
            check($sformatf("md_hold4_c%0d_md4", c), {25'd0, o4}, {25'd0, busy4[c]});
            check($sformatf("md_hold4_c%0d_md2", c), {25'd0, o2}, {25'd0, busy2[c]});
            advance();
        end
        check("md_hold4_stallcnt_md4", sc4, 32'd3);
        check("md_hold4_stallcnt_md2", sc2, 32'd2);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        advance();

        // Mul/div held two cycles: one stall for MD_CYCLES=2.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0, (c < 2));
            if (c < 2) check($sformatf("md_hold2_c%0d_md2", c), {25'd0, o2},
                             {25'd0, (c == 0) ? O_MD : O_NONE});
            check($sformatf("md_hold2_c%0d_md4", c), {25'd0, o4}, {25'd0, busy4[c]});
            advance();
        end
        check("md_hold2_stallcnt_md2", sc2, 32'd1);
        check("md_hold2_stallcnt_md4", sc4, 32'd3);

        // Release cycle: MDStart still high is ignored, load-use still seen.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
            advance();
        end
        apply(0, 1, 5'd7, 5'd7, 5'd0, 0, 1, 0, 1);
        check("md_done_lu_md4", {25'd0, o4}, {25'd0, O_LU});
        check("md_done_lu_md2", {25'd0, o2}, {25'd0, O_LU});
        advance();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("after_done_md4", {25'd0, o4}, 32'd0);
        advance();

        // Reset during the second MD_WAIT cycle abandons the stall.
        do_reset();
        for (int c = 0; c < 2; c++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
            advance();
        end
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_mid_out_md4", {25'd0, o4}, 32'd0);
        advance();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_after_out_md4", {25'd0, o4}, 32'd0);
        check("rst_after_out_md2", {25'd0, o2}, 32'd0);
        check("rst_after_stallcnt", sc4, 32'd0);
        check("rst_after_flushcnt", fc4, 32'd0);
        advance();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            apply(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
